platformniosci_jtag_scan_master: RTL and testbench

//  Host-side JTAG scan engine. It drives TCK/TMS/TDI into a TAP (such as the Nios II debug

---
 rtl/platformniosci_jtag_scan_master_if.sv | 28 ++
 rtl/platformniosci_jtag_scan_master.sv | 167 ++++++++++++++++
 tb/tb_platformniosci_jtag_scan_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/platformniosci_jtag_scan_master_if.sv
// Command/response handshake bundle for the JTAG scan master.
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd_op              : 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle TCKs
//   cmd_len             : bits to shift or TCK count
//   cmd_data            : TDI bits, LSB shifted first
//   rsp_valid           : one-cycle completion pulse
//   rsp_data            : captured TDO, right-justified
interface platformniosci_jtag_scan_master_if #(
  parameter int unsigned MAX_LEN = 64
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [6:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/platformniosci_jtag_scan_master.sv
// Host-side JTAG scan engine: runs TAP-reset, IR/DR scans and idle TCKs,
// returning captured TDO as one response per command.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : command/response interface (slave side)
//   busy       : command or power-on TAP reset in progress
//   tck/tms/tdi: registered JTAG outputs
//   tdo        : JTAG data from target, sampled on the TCK rising clk edge
module platformniosci_jtag_scan_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  platformniosci_jtag_scan_master_if.slave   bus,
  output logic                               busy,
  output logic                               tck,
  output logic                               tms,
  output logic                               tdi,
  input  logic                               tdo
);

  localparam int unsigned CW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int unsigned SW = 8;
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0]  MAX_LEN7 = 7'(MAX_LEN);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [6:0]         len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic [SW-1:0]      step_q;   // index of the next TAP step to launch
  logic [CW-1:0]      cnt_q;    // position within the current TCK period
  logic               auto_q;   // power-on TAP reset: no response

  // Clamp the requested length into 1..MAX_LEN.
  logic [6:0] len_eff;
  assign len_eff = (bus.cmd_len == 7'd0)    ? 7'd1 :
                   (bus.cmd_len > MAX_LEN7) ? MAX_LEN7 : bus.cmd_len;

  // Decode the step about to be launched from the latched command.
  logic [SW-1:0] hdr_len, shift_end, total;
  logic          shift_op, in_hdr, in_shift, tms_n, tdi_n;
  logic [IW-1:0] shift_idx, cap_idx;
  state_t        state_n;

  always_comb begin
    hdr_len   = SW'(len_q);
    shift_op  = (op_q == OP_IR) || (op_q == OP_DR);
    tms_n     = 1'b0;
    tdi_n     = 1'b0;
    state_n   = S_PRE;
    case (op_q)
      OP_RST:  hdr_len = SW'(6);
      OP_IR:   hdr_len = SW'(4);
      OP_DR:   hdr_len = SW'(3);
      default: hdr_len = SW'(len_q);
    endcase
    shift_end = hdr_len + SW'(len_q);
    total     = shift_op ? shift_end + SW'(2) : hdr_len;
    in_hdr    = step_q < hdr_len;
    in_shift  = shift_op && !in_hdr && (step_q < shift_end);
    shift_idx = IW'(step_q - hdr_len);
    cap_idx   = IW'(step_q - SW'(1) - hdr_len);
    if (in_hdr) begin
      state_n = S_PRE;
      case (op_q)
        OP_RST:  tms_n = step_q < SW'(5);
        OP_IR:   tms_n = step_q < SW'(2);
        OP_DR:   tms_n = step_q == SW'(0);
        default: tms_n = 1'b0;
      endcase
    end else if (in_shift) begin
      state_n = S_SHIFT;
      tms_n   = step_q == (shift_end - SW'(1));
      tdi_n   = data_q[shift_idx];
    end else begin
      // Exit1 -> Update (tms=1), then Update -> RTI (tms=0).
      state_n = S_POST;
      tms_n   = step_q == shift_end;
    end
  end

  // Command sequencer and registered JTAG pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_PRE;
      op_q          <= OP_RST;
      len_q         <= 7'd1;
      data_q        <= '0;
      cap_q         <= '0;
      step_q        <= '0;
      cnt_q         <= '0;
      auto_q        <= 1'b1;
      tck           <= 1'b0;
      tms           <= 1'b1;
      tdi           <= 1'b0;
      busy          <= 1'b1;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          tck <= 1'b0;
          tms <= 1'b0;
          tdi <= 1'b0;
          if (bus.cmd_valid && bus.cmd_ready) begin
            op_q          <= bus.cmd_op;
            len_q         <= len_eff;
            data_q        <= bus.cmd_data;
            cap_q         <= '0;
            step_q        <= '0;
            cnt_q         <= '0;
            auto_q        <= 1'b0;
            busy          <= 1'b1;
            bus.cmd_ready <= 1'b0;
            state         <= S_PRE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PRE, S_SHIFT, S_POST: begin
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
          if (cnt_q == '0) begin
            tck <= 1'b0;
            if (step_q == total) begin
              // All steps done; back in Run-Test/Idle.
              cnt_q         <= '0;
              tms           <= 1'b0;
              tdi           <= 1'b0;
              busy          <= 1'b0;
              bus.cmd_ready <= 1'b1;
              if (auto_q) begin
                state <= S_IDLE;
              end else begin
                state         <= S_DONE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= cap_q;
              end
            end else begin
              tms    <= tms_n;
              tdi    <= tdi_n;
              state  <= state_n;
              step_q <= step_q + SW'(1);
            end
          end else if (cnt_q == CNT_RISE) begin
            tck <= 1'b1;
            if (state == S_SHIFT) cap_q[cap_idx] <= tdo;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platformniosci_jtag_scan_master.sv
module tb_platformniosci_jtag_scan_master;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, tck, tms, tdi, tdo;
  logic tdo_mode = 1'b0;   // 0: loopback tdi->tdo, 1: constant
  logic tdo_const = 1'b0;

  always #5 clk = ~clk;
  assign tdo = tdo_mode ? tdo_const : tdi;

  platformniosci_jtag_scan_master_if #(.MAX_LEN(MAX_LEN)) bus();

  platformniosci_jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected JTAG behaviour of one command, derived from the TAP sequences.
  bit          exp_tms[$];
  bit          exp_tdi[$];
  logic [63:0] exp_rsp = '0;
  logic [63:0] last_rsp = '0;
  int          exp_lat = 0;
  bit          pend_rsp = 1'b0;
  bit          pend_auto = 1'b0;

  task automatic push_step(input bit m, input bit d);
    exp_tms.push_back(m);
    exp_tdi.push_back(d);
  endtask

  task automatic build_model(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    int n;
    n = (len == 7'd0) ? 1 : ((int'(len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len));
    exp_tms.delete();
    exp_tdi.delete();
    exp_rsp = '0;
    case (op)
      2'b00: for (int i = 0; i < 6; i++) push_step(i < 5, 1'b0);
      2'b11: for (int i = 0; i < n; i++) push_step(1'b0, 1'b0);
      default: begin
        push_step(1'b1, 1'b0);
        if (op == 2'b01) push_step(1'b1, 1'b0);
        push_step(1'b0, 1'b0);
        push_step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
          push_step(i == n - 1, data[i]);
          exp_rsp[i] = tdo_mode ? tdo_const : data[i];
        end
        push_step(1'b1, 1'b0);
        push_step(1'b0, 1'b0);
      end
    endcase
    exp_lat = 1 + 2 * int'(CLK_DIV) * exp_tms.size();
  endtask

  // Compare DUT pins against the model on every clk (sampled on negedge).
  bit prev_tck = 1'b0;
  bit prev_ready = 1'b0;
  bit m_t, m_d;
  always @(negedge clk) begin
    if (!reset) begin
      if (tck && !prev_tck) begin
        if (exp_tms.size() == 0) begin
          check("extra_tck", 64'(1), 64'(0));
        end else begin
          m_t = exp_tms.pop_front();
          m_d = exp_tdi.pop_front();
          check("tms_step", 64'(tms), 64'(m_t));
          check("tdi_step", 64'(tdi), 64'(m_d));
        end
      end
      if (bus.rsp_valid) begin
        if (!pend_rsp) begin
          check("spurious_rsp", 64'(1), 64'(0));
        end else begin
          check("rsp_data", bus.rsp_data, exp_rsp);
          check("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
          check("steps_left", 64'(exp_tms.size()), 64'(0));
          last_rsp = exp_rsp;
          pend_rsp = 1'b0;
        end
      end else begin
        check("rsp_hold", bus.rsp_data, last_rsp);
      end
      if (bus.cmd_ready && !prev_ready && pend_auto) begin
        check("auto_latency", 64'(cyc - rel_cyc), 64'(6 * 2 * CLK_DIV + 1));
        check("auto_steps_left", 64'(exp_tms.size()), 64'(0));
        pend_auto = 1'b0;
      end
      check("ready_vs_busy", 64'(bus.cmd_ready), 64'(!busy));
      if (!busy) begin
        check("idle_tck", 64'(tck), 64'(0));
        check("idle_tms", 64'(tms), 64'(0));
      end
    end
    prev_tck = tck;
    prev_ready = bus.cmd_ready;
  end

  task automatic release_reset();
    build_model(2'b00, 7'd0, 64'd0);
    pend_auto = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_auto();
    int n = 0;
    while (pend_auto && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (pend_auto) begin
      check("auto_timeout", 64'(0), 64'(1));
      pend_auto = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.cmd_ready && n < 2000);
    if (!bus.cmd_ready) begin
      check("ready_timeout", 64'(0), 64'(1));
      return;
    end
    build_model(op, len, data);
    pend_rsp = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_len = len;
    bus.cmd_data = data;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend_rsp && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (pend_rsp) begin
      check("rsp_timeout", 64'(0), 64'(1));
      pend_rsp = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_len = 7'd0;
    bus.cmd_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'(0));
    check("rst_tms", 64'(tms), 64'(1));
    check("rst_tdi", 64'(tdi), 64'(0));
    check("rst_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'(1));

    // Power-on TAP reset
    release_reset();
    wait_auto();

    // DR scan len 8 loopback
    tdo_mode = 1'b0;
    send(2'b10, 7'd8, 64'hA5);
    check("model_lat_dr8", 64'(exp_lat), 64'(53));
    wait_done();
    check("dr8_rsp_lit", bus.rsp_data, 64'hA5);

    // IR scan len 2, tdo tied high
    tdo_mode = 1'b1;
    tdo_const = 1'b1;
    send(2'b01, 7'd2, 64'h2);
    check("model_lat_ir2", 64'(exp_lat), 64'(1 + 4 * 8));
    wait_done();
    check("ir2_rsp_lit", bus.rsp_data, 64'h3);

    // DR scan full width loopback
    tdo_mode = 1'b0;
    send(2'b10, 7'd64, 64'hDEADBEEF_01234567);
    check("model_lat_dr64", 64'(exp_lat), 64'(1 + 4 * 69));
    wait_done();
    check("dr64_rsp_lit", bus.rsp_data, 64'hDEADBEEF_01234567);

    // Idle len 0 acts as 1 TCK
    send(2'b11, 7'd0, '1);
    check("model_lat_idle0", 64'(exp_lat), 64'(5));
    wait_done();
    check("idle0_rsp_lit", bus.rsp_data, 64'd0);

    // Explicit TAP reset command
    send(2'b00, 7'd7, '1);
    wait_done();
    check("tapreset_rsp_lit", bus.rsp_data, 64'd0);

    // Length above MAX_LEN clamps
    send(2'b10, 7'd100, 64'h01234567_89ABCDEF);
    check("model_lat_clamp", 64'(exp_lat), 64'(1 + 4 * 69));
    wait_done();
    check("clamp_rsp_lit", bus.rsp_data, 64'h01234567_89ABCDEF);

    // DR len 0 acts as 1 bit, tdo high
    tdo_mode = 1'b1;
    tdo_const = 1'b1;
    send(2'b10, 7'd0, 64'd0);
    check("model_lat_dr0", 64'(exp_lat), 64'(1 + 4 * 6));
    wait_done();
    check("dr0_rsp_lit", bus.rsp_data, 64'h1);

    // cmd_valid while busy is ignored, not queued
    tdo_mode = 1'b0;
    send(2'b11, 7'd3, 64'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b10;
    bus.cmd_len = 7'd5;
    repeat (5) @(negedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    check("not_queued_busy", 64'(busy), 64'(0));

    // Reset mid-shift aborts the command
    send(2'b10, 7'd32, 64'hCAFEF00D_12345678);
    repeat (31) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_tck", 64'(tck), 64'(0));
    check("abort_tms", 64'(tms), 64'(1));
    check("abort_ready", 64'(bus.cmd_ready), 64'(0));
    check("abort_busy", 64'(busy), 64'(1));
    pend_rsp = 1'b0;
    exp_tms.delete();
    exp_tdi.delete();
    last_rsp = '0;
    repeat (2) @(negedge clk);
    release_reset();
    wait_auto();
    repeat (4) @(negedge clk);
    check("abort_rsp_data", bus.rsp_data, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
